out_port_ctrl: RTL and testbench
================================

// Module: out_port_ctrl
// PURPOSE
//  Output-port controller for the datapath: counterpart of the input port. On an `out` instruction,
//  OutPortenable strobes the BusMuxOut word into a small FIFO. Words are then delivered to the
//  external device over a valid/ready handshake, so the CPU never waits on a slow consumer
//  unless the FIFO is full. Sits beside the register file on the bus; no bus drive-back.
// PARAMETERS
//  DATA_WIDTH  32  width of bus word and port_data
//  DEPTH       4   FIFO entries; power of two, >=2
//  PTR_W       2   log2(DEPTH); must equal $clog2(DEPTH)
// PORTS
//  clock         in   1           rising-edge system clock
//  clear         in   1           asynchronous, active-low reset
//  BusMuxOut     in   DATA_WIDTH  datapath bus, sampled on push
//  OutPortenable in   1           push strobe, one word per clock it is high
//  ovf_clr       in   1           synchronous clear of sticky overflow
//  port_ready    in   1           external device accepts port_data this cycle
//  port_data     out  DATA_WIDTH  FIFO head word (valid only when port_valid=1)
//  port_valid    out  1           FIFO non-empty
//  full          out  1           count==DEPTH; CPU control unit should hold off `out`
//  count         out  PTR_W+1     occupancy 0..DEPTH
//  overflow      out  1           sticky: push attempted while full and not popping
//  port_parity   out  1           even parity of port_data (only with OUTPORT_PARITY_EN)
// BEHAVIOUR
//  - Reset (clear=0, any time, mid-transfer included): wr_ptr=rd_ptr=0, count=0, overflow=0,
//    port_valid=0, full=0, port_data=0, port_parity=0. Storage contents not cleared.
//  - push = OutPortenable; pop = port_valid & port_ready (handshake: transfer on edge where both high).
//  - port_valid and port_data stay stable until a pop; device may hold port_ready high continuously.
//  - Push accepted iff count<DEPTH, or count==DEPTH with pop in the same cycle (count unchanged).
//  - Push rejected (full, no pop): word dropped, overflow<=1, pointers/count unchanged.
//  - overflow: set by rejected push, cleared by ovf_clr; set wins if both in same cycle.
//  - Push and pop same cycle, 0<count<DEPTH: both occur, count unchanged.
//  - Push into empty FIFO: port_valid=1 and port_data=pushed word from the next cycle (1-cycle latency);
//    no same-cycle bypass. pop with count==0 impossible (port_valid=0).
//  - Pointers PTR_W bits, wrap DEPTH-1 -> 0; count is separate PTR_W+1-bit counter.
//  - port_data = mem[rd_ptr] when count>0, else 0 (never shows stale data).
//  - Occupancy states EMPTY(count=0) / PARTIAL / FULL(count=DEPTH); transitions only by +1/-1/0
//    per cycle as above. full and port_valid decoded from count, glitch-free (registered count).
//  - X on BusMuxOut is stored as-is; no checks.
// CONFIGURATION
//  OUTPORT_PARITY_EN defined: port_parity present = ^port_data (0 when empty), one extra output.
//  Not defined: port_parity port absent from the module; all other behaviour identical.
// TESTING
//  1 reset: clear=0 mid-stream with count=3 -> count=0, port_valid=0, overflow=0, port_data=0 immediately.
//  2 push 32'h0000_00A5, port_ready=0 -> next cycle port_valid=1, port_data=A5, count=1; holds 5 cycles.
//  3 push A,B,C,D (ready=0) -> full=1,count=4; push E -> overflow=1, E dropped; ready=1 x4 -> A,B,C,D in order, count=0.
//  4 full, push F with ready=1 same cycle -> A popped, F accepted, count stays 4, overflow stays 0; drain B,C,D,F.
//  5 push+pop every cycle for 10 words with ready=1 -> each word seen once, in order, pointers wrap, count<=1.
//  6 OUTPORT_PARITY_EN: push 32'h0000_0007 -> port_parity=1; push 32'h0000_0003 -> port_parity=0 after pop.

Source files
------------

// File: rtl/out_port_ctrl.sv
// out_port_ctrl: output-port FIFO that takes bus words on OutPortenable and delivers them over valid/ready.
// Define OUTPORT_PARITY_EN to add the port_parity output (even parity of port_data).
module out_port_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = 2
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] BusMuxOut,
    input  logic                  OutPortenable,
    input  logic                  ovf_clr,
    input  logic                  port_ready,
    output logic [DATA_WIDTH-1:0] port_data,
    output logic                  port_valid,
    output logic                  full,
    output logic [PTR_W:0]        count,
    output logic                  overflow
`ifdef OUTPORT_PARITY_EN
    ,
    output logic                  port_parity
`endif
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  pop, push_ok, push_drop;

    // Status is decoded from the registered count only, so it cannot glitch.
    assign port_valid = count_q != '0;
    assign full       = count_q == (PTR_W+1)'(DEPTH);
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign port_data  = port_valid ? mem_q[rd_ptr_q] : '0;
`ifdef OUTPORT_PARITY_EN
    assign port_parity = ^port_data;
`endif

    always_comb begin
        pop        = port_valid & port_ready;
        push_ok    = OutPortenable & (~full | pop);
        push_drop  = OutPortenable & full & ~pop;
        wr_ptr_d   = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
        overflow_d = push_drop ? 1'b1 : ovf_clr ? 1'b0 : overflow_q;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left out of reset; port_data masks it while empty.
    always_ff @(posedge clock) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= BusMuxOut;
    end
endmodule

// File: tb/tb_out_port_ctrl.sv
// tb_out_port_ctrl: directed and randomized checks of out_port_ctrl against a queue-based FIFO model.
module tb_out_port_ctrl;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          clear = 1'b0;
    logic [DW-1:0] BusMuxOut = '0;
    logic          OutPortenable = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          port_ready = 1'b0;
    logic [DW-1:0] port_data;
    logic          port_valid;
    logic          full;
    logic [2:0]    count;
    logic          overflow;
`ifdef OUTPORT_PARITY_EN
    logic          port_parity;
`endif

    out_port_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_W(2)) dut (
        .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut), .OutPortenable(OutPortenable),
        .ovf_clr(ovf_clr), .port_ready(port_ready), .port_data(port_data),
        .port_valid(port_valid), .full(full), .count(count), .overflow(overflow)
`ifdef OUTPORT_PARITY_EN
        , .port_parity(port_parity)
`endif
    );

    always #5 clock = ~clock;

    logic [DW-1:0] q[$];
    logic          m_ovf = 1'b0;
    int            n_chk = 0;
    int            n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [DW-1:0] hd;
        hd = (q.size() > 0) ? q[0] : '0;
        chk({tag, ".count"}, 64'(count), 64'(q.size()));
        chk({tag, ".valid"}, 64'(port_valid), 64'(q.size() > 0));
        chk({tag, ".full"}, 64'(full), 64'(q.size() == DEPTH));
        chk({tag, ".data"}, 64'(port_data), 64'(hd));
        chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
`ifdef OUTPORT_PARITY_EN
        chk({tag, ".par"}, 64'(port_parity), 64'(^hd));
`endif
    endtask

    task automatic step(input logic push, input logic [DW-1:0] d, input logic rdy, input logic oc,
                        input string tag);
        logic pop, acc;
        OutPortenable = push;
        BusMuxOut     = d;
        port_ready    = rdy;
        ovf_clr       = oc;
        pop = (q.size() > 0) && rdy;
        acc = push && ((q.size() < DEPTH) || pop);
        @(posedge clock);
        #1;
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(d);
        m_ovf = (push && !acc) ? 1'b1 : oc ? 1'b0 : m_ovf;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        clear = 1'b0;
        OutPortenable = 1'b0;
        port_ready = 1'b0;
        ovf_clr = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        check_all(tag);
        @(posedge clock);
        #1;
        check_all({tag, ".hold"});
        clear = 1'b1;
    endtask

    initial begin
        do_reset("init");

        // reset mid-stream with count=3 and overflow set
        for (int i = 0; i < 5; i++) step(1'b1, 32'h100 + i, 1'b0, 1'b0, "t1.fill");
        step(1'b0, '0, 1'b1, 1'b0, "t1.pop");
        chk("t1.pre_cnt", 64'(count), 64'd3);
        chk("t1.pre_ovf", 64'(overflow), 64'd1);
        #2;
        do_reset("t1.rst");
        chk("t1.cnt0", 64'(count), 64'd0);

        // single push, latency and hold
        step(1'b1, 32'h0000_00A5, 1'b0, 1'b0, "t2.push");
        chk("t2.data", 64'(port_data), 64'hA5);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b0, "t2.hold");
        chk("t2.data_held", 64'(port_data), 64'hA5);
        step(1'b0, '0, 1'b1, 1'b0, "t2.drain");

        // fill, overflow, set-wins, clear, drain in order
        step(1'b1, 32'hA, 1'b0, 1'b0, "t3.push");
        step(1'b1, 32'hB, 1'b0, 1'b0, "t3.push");
        step(1'b1, 32'hC, 1'b0, 1'b0, "t3.push");
        step(1'b1, 32'hD, 1'b0, 1'b0, "t3.push");
        chk("t3.full", 64'(full), 64'd1);
        step(1'b1, 32'hE, 1'b0, 1'b0, "t3.drop");
        chk("t3.ovf", 64'(overflow), 64'd1);
        step(1'b1, 32'hE, 1'b0, 1'b1, "t3.setwins");
        chk("t3.ovf_setwins", 64'(overflow), 64'd1);
        step(1'b0, '0, 1'b0, 1'b1, "t3.ovfclr");
        chk("t3.ovf_clr", 64'(overflow), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t3.order", 64'(port_data), 64'(32'hA + i));
            step(1'b0, '0, 1'b1, 1'b0, "t3.drain");
        end
        chk("t3.empty", 64'(count), 64'd0);

        // push while full with a simultaneous pop
        for (int i = 0; i < 4; i++) step(1'b1, 32'hA + i, 1'b0, 1'b0, "t4.fill");
        step(1'b1, 32'hF, 1'b1, 1'b0, "t4.pushpop");
        chk("t4.cnt4", 64'(count), 64'd4);
        chk("t4.ovf0", 64'(overflow), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t4.order", 64'(port_data), 64'((i == 3) ? 32'hF : 32'hB + i));
            step(1'b0, '0, 1'b1, 1'b0, "t4.drain");
        end

        // streaming with ready held high, pointers wrap
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h5000 + i, 1'b1, 1'b0, "t5.stream");
            chk("t5.order", 64'(port_data), 64'(32'h5000 + i));
            chk("t5.cnt_le1", 64'(count <= 3'd1), 64'd1);
        end
        step(1'b0, '0, 1'b1, 1'b0, "t5.drain");

`ifdef OUTPORT_PARITY_EN
        step(1'b1, 32'h0000_0007, 1'b0, 1'b0, "t6.push7");
        chk("t6.par1", 64'(port_parity), 64'd1);
        step(1'b1, 32'h0000_0003, 1'b1, 1'b0, "t6.push3");
        chk("t6.par0", 64'(port_parity), 64'd0);
        step(1'b0, '0, 1'b1, 1'b0, "t6.drain");
        chk("t6.par_empty", 64'(port_parity), 64'd0);
`endif

        // randomized traffic with occasional clears and resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                #2;
                do_reset("rnd.rst");
            end else begin
                step($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 45,
                     $urandom_range(0, 99) < 5, "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
